// File: rtl/stateful_sub_array.sv
// Indexed predicated add/subtract stateful atom: DEPTH cells of WIDTH bits, two-stage pipeline with forwarding.
// Optional clamping of the update to [0, 2^WIDTH-1] when STATEFUL_SUB_SAT_EN is defined (modulo wrap otherwise).
module stateful_sub_array #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int IDXW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDXW-1:0]  in_idx,
    input  logic [WIDTH-1:0] pkt_1,
    input  logic [WIDTH-1:0] pkt_2,
    input  logic [WIDTH-1:0] cons_1,
    input  logic [WIDTH-1:0] cons_2,
    input  logic [WIDTH-1:0] cons_3,
    input  logic [WIDTH-1:0] cons_4,
    input  logic [WIDTH-1:0] cons_5,
    input  logic             sel_1,
    input  logic [1:0]       sel_2,
    input  logic             sel_3,
    input  logic [1:0]       sel_4,
    input  logic             sel_5,
    input  logic [1:0]       sel_6,
    input  logic [1:0]       sel_7,
    input  logic [1:0]       sel_8,
    input  logic [1:0]       rel_opcode,
    output logic             out_valid,
    output logic [IDXW-1:0]  out_idx,
    output logic [WIDTH-1:0] o__read,
    output logic [WIDTH-1:0] o__write
);

    // Valid-only handshake: in_valid=1 means a packet is accepted this cycle (no ready,
    // no backpressure); out_valid pulses for exactly one cycle two edges later.

    logic [WIDTH-1:0] cells [DEPTH];

    logic             s1_valid;
    logic [IDXW-1:0]  s1_idx;
    logic [WIDTH-1:0] s1_pkt_1, s1_pkt_2;
    logic [WIDTH-1:0] s1_cons_1, s1_cons_2, s1_cons_3, s1_cons_4, s1_cons_5;
    logic             s1_sel_1, s1_sel_3, s1_sel_5;
    logic [1:0]       s1_sel_2, s1_sel_4, s1_sel_6, s1_sel_7, s1_sel_8;
    logic [1:0]       s1_rel;
    logic [WIDTH-1:0] s1_s;

    logic [WIDTH-1:0] new_val;
    logic [WIDTH-1:0] pred_lhs, pred_rhs;
    logic             pred;
    logic [WIDTH-1:0] upd_base, upd_add, upd_sub;

    function automatic logic [WIDTH-1:0] mux3(input logic [1:0] sel,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
        case (sel)
            2'd0:    return a;
            2'd1:    return b;
            default: return c;
        endcase
    endfunction

    // S2: predicate and update computed from the S1 registers
    always_comb begin
        pred_lhs = s1_sel_1 ? '0 : s1_s;
        pred_rhs = mux3(s1_sel_2, s1_pkt_1, s1_pkt_2, s1_cons_1);
        case (s1_rel)
            2'd0:    pred = (pred_lhs != pred_rhs);
            2'd1:    pred = (pred_lhs <  pred_rhs);
            2'd2:    pred = (pred_lhs >  pred_rhs);
            default: pred = (pred_lhs == pred_rhs);
        endcase
        if (pred) begin
            upd_base = s1_sel_3 ? '0 : s1_s;
            upd_add  = mux3(s1_sel_4, s1_pkt_1, s1_pkt_2, s1_cons_2);
            upd_sub  = mux3(s1_sel_7, s1_pkt_1, s1_pkt_2, s1_cons_4);
        end else begin
            upd_base = s1_sel_5 ? '0 : s1_s;
            upd_add  = mux3(s1_sel_6, s1_pkt_1, s1_pkt_2, s1_cons_3);
            upd_sub  = mux3(s1_sel_8, s1_pkt_1, s1_pkt_2, s1_cons_5);
        end
    end

`ifdef STATEFUL_SUB_SAT_EN
    // Two guard bits hold the full range -(2^WIDTH-1) .. 2*(2^WIDTH-1)
    logic signed [WIDTH+1:0] sum_x;
    always_comb begin
        sum_x = $signed({2'b00, upd_base}) + $signed({2'b00, upd_add}) - $signed({2'b00, upd_sub});
        if (sum_x[WIDTH+1])
            new_val = '0;
        else if (sum_x[WIDTH])
            new_val = '1;
        else
            new_val = sum_x[WIDTH-1:0];
    end
`else
    always_comb begin
        new_val = upd_base + upd_add - upd_sub;
    end
`endif

    // S1 capture; forwarding keeps back-to-back same-index packets serial
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_idx    <= '0;
            s1_pkt_1  <= '0;
            s1_pkt_2  <= '0;
            s1_cons_1 <= '0;
            s1_cons_2 <= '0;
            s1_cons_3 <= '0;
            s1_cons_4 <= '0;
            s1_cons_5 <= '0;
            s1_sel_1  <= 1'b0;
            s1_sel_3  <= 1'b0;
            s1_sel_5  <= 1'b0;
            s1_sel_2  <= '0;
            s1_sel_4  <= '0;
            s1_sel_6  <= '0;
            s1_sel_7  <= '0;
            s1_sel_8  <= '0;
            s1_rel    <= '0;
            s1_s      <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_idx    <= in_idx;
                s1_pkt_1  <= pkt_1;
                s1_pkt_2  <= pkt_2;
                s1_cons_1 <= cons_1;
                s1_cons_2 <= cons_2;
                s1_cons_3 <= cons_3;
                s1_cons_4 <= cons_4;
                s1_cons_5 <= cons_5;
                s1_sel_1  <= sel_1;
                s1_sel_3  <= sel_3;
                s1_sel_5  <= sel_5;
                s1_sel_2  <= sel_2;
                s1_sel_4  <= sel_4;
                s1_sel_6  <= sel_6;
                s1_sel_7  <= sel_7;
                s1_sel_8  <= sel_8;
                s1_rel    <= rel_opcode;
                s1_s      <= (s1_valid && (s1_idx == in_idx)) ? new_val : cells[in_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) cells[i] <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            o__read   <= '0;
            o__write  <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                cells[s1_idx] <= new_val;
                out_idx       <= s1_idx;
                o__read       <= s1_s;
                o__write      <= new_val;
            end
        end
    end

endmodule

// File: tb/tb_stateful_sub_array.sv
// Scoreboard bench for stateful_sub_array (WIDTH=8, DEPTH=4); honours STATEFUL_SUB_SAT_EN in its model.
module tb_stateful_sub_array;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int IDXW  = 2;
    localparam int EW    = 32 + IDXW + 2 * WIDTH;
    localparam longint MODV = longint'(1) << WIDTH;

    typedef struct packed {
        logic [WIDTH-1:0] cons_1, cons_2, cons_3, cons_4, cons_5;
        logic             sel_1, sel_3, sel_5;
        logic [1:0]       sel_2, sel_4, sel_6, sel_7, sel_8;
        logic [1:0]       rel;
    } cfg_t;

    logic             clk, rst_n, in_valid;
    logic [IDXW-1:0]  in_idx;
    logic [WIDTH-1:0] pkt_1, pkt_2;
    logic [WIDTH-1:0] cons_1, cons_2, cons_3, cons_4, cons_5;
    logic             sel_1, sel_3, sel_5;
    logic [1:0]       sel_2, sel_4, sel_6, sel_7, sel_8, rel_opcode;
    logic             out_valid;
    logic [IDXW-1:0]  out_idx;
    logic [WIDTH-1:0] o__read, o__write;

    cfg_t cfg_pin;
    assign cons_1 = cfg_pin.cons_1;
    assign cons_2 = cfg_pin.cons_2;
    assign cons_3 = cfg_pin.cons_3;
    assign cons_4 = cfg_pin.cons_4;
    assign cons_5 = cfg_pin.cons_5;
    assign sel_1 = cfg_pin.sel_1;
    assign sel_3 = cfg_pin.sel_3;
    assign sel_5 = cfg_pin.sel_5;
    assign sel_2 = cfg_pin.sel_2;
    assign sel_4 = cfg_pin.sel_4;
    assign sel_6 = cfg_pin.sel_6;
    assign sel_7 = cfg_pin.sel_7;
    assign sel_8 = cfg_pin.sel_8;
    assign rel_opcode = cfg_pin.rel;

    stateful_sub_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_idx(in_idx),
        .pkt_1(pkt_1), .pkt_2(pkt_2),
        .cons_1(cons_1), .cons_2(cons_2), .cons_3(cons_3), .cons_4(cons_4), .cons_5(cons_5),
        .sel_1(sel_1), .sel_2(sel_2), .sel_3(sel_3), .sel_4(sel_4), .sel_5(sel_5),
        .sel_6(sel_6), .sel_7(sel_7), .sel_8(sel_8), .rel_opcode(rel_opcode),
        .out_valid(out_valid), .out_idx(out_idx), .o__read(o__read), .o__write(o__write)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0]    exp_q[$];
    longint           model_cells[DEPTH];
    logic [IDXW-1:0]  last_idx;
    logic [WIDTH-1:0] last_read, last_write;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint pick(input logic [1:0] sel, input longint a, input longint b, input longint c);
        if (sel == 2'd0) return a;
        if (sel == 2'd1) return b;
        return c;
    endfunction

    // Reference: the state update rule evaluated with plain integer arithmetic
    function automatic longint ref_update(input cfg_t c, input longint s, input longint p1, input longint p2);
        longint lhs, rhs, v;
        bit p;
        lhs = c.sel_1 ? 0 : s;
        rhs = pick(c.sel_2, p1, p2, longint'(c.cons_1));
        case (c.rel)
            2'd0: p = (lhs != rhs);
            2'd1: p = (lhs < rhs);
            2'd2: p = (lhs > rhs);
            default: p = (lhs == rhs);
        endcase
        if (p) v = (c.sel_3 ? 0 : s) + pick(c.sel_4, p1, p2, longint'(c.cons_2)) - pick(c.sel_7, p1, p2, longint'(c.cons_4));
        else   v = (c.sel_5 ? 0 : s) + pick(c.sel_6, p1, p2, longint'(c.cons_3)) - pick(c.sel_8, p1, p2, longint'(c.cons_5));
`ifdef STATEFUL_SUB_SAT_EN
        if (v < 0) v = 0;
        else if (v > MODV - 1) v = MODV - 1;
`else
        v = ((v % MODV) + MODV) % MODV;
`endif
        return v;
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.cons_1 = WIDTH'($urandom); c.cons_2 = WIDTH'($urandom); c.cons_3 = WIDTH'($urandom);
        c.cons_4 = WIDTH'($urandom); c.cons_5 = WIDTH'($urandom);
        c.sel_1 = 1'($urandom); c.sel_3 = 1'($urandom); c.sel_5 = 1'($urandom);
        c.sel_2 = 2'($urandom); c.sel_4 = 2'($urandom); c.sel_6 = 2'($urandom);
        c.sel_7 = 2'($urandom); c.sel_8 = 2'($urandom); c.rel = 2'($urandom);
        return c;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input int idx, input int p1, input int p2, input cfg_t c);
        logic [IDXW-1:0]  e_idx;
        logic [WIDTH-1:0] e_s, e_n;
        logic [31:0]      e_cyc;
        longint s, n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_idx   = IDXW'(idx);
        pkt_1    = WIDTH'(p1);
        pkt_2    = WIDTH'(p2);
        cfg_pin  = c;
        s = model_cells[idx];
        n = ref_update(c, s, longint'(pkt_1), longint'(pkt_2));
        model_cells[idx] = n;
        e_cyc = 32'(cyc); e_idx = IDXW'(idx); e_s = WIDTH'(s); e_n = WIDTH'(n);
        exp_q.push_back({e_cyc, e_idx, e_s, e_n});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_idx   = IDXW'($urandom);
            pkt_1    = WIDTH'($urandom);
            pkt_2    = WIDTH'($urandom);
            cfg_pin  = rand_cfg();
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) model_cells[i] = 0;
        last_idx = '0; last_read = '0; last_write = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        clear_model();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    check("latency", cyc, longint'(e[EW-1 -: 32]) + 2);
                    check("out_idx", out_idx, e[2*WIDTH +: IDXW]);
                    check("o__read", o__read, e[WIDTH +: WIDTH]);
                    check("o__write", o__write, e[0 +: WIDTH]);
                    last_idx = e[2*WIDTH +: IDXW];
                    last_read = e[WIDTH +: WIDTH];
                    last_write = e[0 +: WIDTH];
                end
            end else begin
                check("hold_idx", out_idx, last_idx);
                check("hold_read", o__read, last_read);
                check("hold_write", o__write, last_write);
            end
        end else begin
            check("reset_out_valid", out_valid, 0);
            check("reset_o__write", o__write, 0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        cfg_t c;
        int wait_cyc;
        rst_n = 1'b1; in_valid = 1'b0; in_idx = '0; pkt_1 = '0; pkt_2 = '0;
        cfg_pin = '0;
        clear_model();
        #2;
        apply_reset();
        idle(3);

        // Predicated counter on idx 3, back-to-back (forwarding every cycle)
        c = '0;
        c.sel_2 = 2; c.cons_1 = 5; c.rel = 1;
        c.sel_4 = 0; c.sel_7 = 2; c.cons_4 = 2;
        c.sel_6 = 2; c.cons_3 = 0; c.sel_8 = 2; c.cons_5 = 1;
        for (int i = 0; i < 3; i++) issue(3, 7, 0, c);
        idle(3);

        // Alternate idx 0/1, s + pkt_1 with an always-true predicate
        c = '0;
        c.sel_1 = 1; c.sel_2 = 2; c.cons_1 = 1; c.rel = 0;
        c.sel_4 = 0; c.sel_7 = 2; c.cons_4 = 0;
        for (int i = 0; i < 8; i++) issue(i % 2, 1, 0, c);
        idle(3);

        // Wrap / clamp: 0 - 1, then 250 + 10
        apply_reset();
        c = '0;
        c.sel_1 = 1; c.sel_2 = 2; c.cons_1 = 1; c.rel = 0;
        c.sel_4 = 2; c.cons_2 = 0; c.sel_7 = 1;
        issue(2, 0, 1, c);
        c.sel_3 = 1; c.cons_2 = 250; c.sel_7 = 2; c.cons_4 = 0;
        issue(2, 0, 0, c);
        c.sel_3 = 0; c.cons_2 = 10;
        issue(2, 0, 0, c);
        idle(3);

        // Bubble between same-index packets: state goes through the array
        c = '0;
        c.sel_1 = 1; c.sel_2 = 2; c.cons_1 = 1; c.rel = 0;
        c.sel_4 = 0; c.sel_7 = 2; c.cons_4 = 0;
        issue(1, 9, 0, c);
        idle(1);
        issue(1, 4, 0, c);
        idle(3);

        // Reset while one packet sits in S1 and the next is on the inputs
        issue(0, 3, 0, c);
        issue(0, 3, 0, c);
        #1;
        apply_reset();
        issue(0, 6, 0, c);
        issue(3, 2, 0, c);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7)
                issue($urandom_range(0, DEPTH - 1), $urandom, $urandom, rand_cfg());
            else
                idle(1);
        end
        idle(1);

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        check("drain_pending", exp_q.size(), 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
